// File: rtl/cond_flags_reg_if.sv
// Bus bundle between the ALU flag generators/consumer and cond_flags_reg.
interface cond_flags_reg_if #(
  parameter int N = 32
);
  logic [N-1:0] result;
  logic         cout_i;
  logic         vflag_i;
  logic [3:0]   alucontrol;
  logic         flag_we;
  logic [3:0]   cond;
  logic         push;
  logic         pop;
  logic [3:0]   nzcv;
  logic         cond_pass;
  logic         stack_empty;
  logic         stack_full;
  logic         stack_err;

  modport master (
    output result, cout_i, vflag_i, alucontrol, flag_we, cond, push, pop,
    input  nzcv, cond_pass, stack_empty, stack_full, stack_err
  );

  modport slave (
    input  result, cout_i, vflag_i, alucontrol, flag_we, cond, push, pop,
    output nzcv, cond_pass, stack_empty, stack_full, stack_err
  );
endinterface

// File: rtl/cond_flags_reg.sv
// NZCV flag register with condition evaluation and a LIFO of saved flag words.
// Define COND_BYPASS_EN to forward same-cycle new flags into cond_pass.
module cond_flags_reg #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  cond_flags_reg_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
    CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
    CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
    CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
  } cond_e;

  logic [3:0]    nzcv;
  logic [3:0]    nzcv_new;
  logic [3:0]    nzcv_nxt;
  logic [3:0]    stack [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          at_full;
  logic          at_empty;
  logic          push_ok;
  logic          pop_ok;
  logic          err_ev;
  logic          err;
  logic          empty;
  logic          full;
  logic [3:0]    eval_flags;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (cond_e'(c))
      CC_EQ:   return z;
      CC_NE:   return !z;
      CC_CS:   return cy;
      CC_CC:   return !cy;
      CC_MI:   return n;
      CC_PL:   return !n;
      CC_VS:   return v;
      CC_VC:   return !v;
      CC_HI:   return cy && !z;
      CC_LS:   return !cy || z;
      CC_GE:   return n == v;
      CC_LT:   return n != v;
      CC_GT:   return !z && (n == v);
      CC_LE:   return z || (n != v);
      CC_AL:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    nzcv_new[3] = bus.result[N-1];
    nzcv_new[2] = (bus.result == '0);
    nzcv_new[1] = bus.alucontrol[1] ? nzcv[1] : bus.cout_i;
    nzcv_new[0] = bus.alucontrol[1] ? nzcv[0] : bus.vflag_i;
  end

  always_comb begin
    at_full  = (count == CW'(DEPTH));
    at_empty = (count == '0);
    push_ok  = bus.push && !bus.pop && !at_full;
    pop_ok   = bus.pop && !bus.push && !at_empty;
    err_ev   = (bus.push && bus.pop) || (bus.push && at_full) || (bus.pop && at_empty);
    wr_idx   = count[AW-1:0];
    rd_idx   = AW'(count - 1'b1);

    count_nxt = count;
    if (push_ok)     count_nxt = count + 1'b1;
    else if (pop_ok) count_nxt = count - 1'b1;

    nzcv_nxt = nzcv;
    if (pop_ok)           nzcv_nxt = stack[rd_idx];
    else if (bus.flag_we) nzcv_nxt = nzcv_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nzcv  <= '0;
      count <= '0;
      err   <= 1'b0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      nzcv  <= nzcv_nxt;
      count <= count_nxt;
      err   <= err || err_ev;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Stack storage needs no reset: the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) stack[wr_idx] <= nzcv;
  end

  always_comb begin
`ifdef COND_BYPASS_EN
    eval_flags = (bus.flag_we && !pop_ok) ? nzcv_new : nzcv;
`else
    eval_flags = nzcv;
`endif
  end

  assign bus.cond_pass   = cond_eval(bus.cond, eval_flags);
  assign bus.nzcv        = nzcv;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.stack_err   = err;
endmodule

// File: tb/tb_cond_flags_reg.sv
// Scoreboard bench for cond_flags_reg: the driver queues hand-computed expectations, a monitor checks them.
module tb_cond_flags_reg;
`ifdef COND_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cond_flags_reg_if #(.N(32)) bus_i ();

  cond_flags_reg #(.N(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  typedef struct {
    string      name;
    logic [3:0] nzcv;
    logic       empty;
    logic       full;
    logic       err;
    logic       pass;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  logic [31:0] s_result;
  logic        s_cout, s_v, s_we, s_push, s_pop, s_rst;
  logic [3:0]  s_alu, s_cond;

  function automatic logic tbl(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;            4'h1: return !z;
      4'h2: return cy;           4'h3: return !cy;
      4'h4: return n;            4'h5: return !n;
      4'h6: return v;            4'h7: return !v;
      4'h8: return cy & !z;      4'h9: return !cy | z;
      4'hA: return n == v;       4'hB: return n != v;
      4'hC: return !z & (n == v); 4'hD: return z | (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clr();
    s_result = '0; s_cout = 0; s_v = 0; s_we = 0; s_push = 0; s_pop = 0;
    s_rst = 0; s_alu = '0; s_cond = 4'hE;
  endtask

  // Expectation describes what is visible during this cycle with the staged inputs applied.
  task automatic tick(input string nm, input logic chk, input logic [3:0] en,
                      input logic ee, input logic ef, input logic er, input logic ep);
    exp_t e;
    @(negedge clk);
    rst              = s_rst;
    bus_i.result     = s_result;
    bus_i.cout_i     = s_cout;
    bus_i.vflag_i    = s_v;
    bus_i.alucontrol = s_alu;
    bus_i.flag_we    = s_we;
    bus_i.cond       = s_cond;
    bus_i.push       = s_push;
    bus_i.pop        = s_pop;
    if (chk) begin
      e.name = nm; e.nzcv = en; e.empty = ee; e.full = ef; e.err = er; e.pass = ep;
      q.push_back(e);
    end
    clr();
  endtask

  task automatic cmp(input string nm, input string fld, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%b expected=%b", nm, fld, got, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e.name, "nzcv",  bus_i.nzcv, e.nzcv);
        cmp(e.name, "empty", {3'b0, bus_i.stack_empty}, {3'b0, e.empty});
        cmp(e.name, "full",  {3'b0, bus_i.stack_full},  {3'b0, e.full});
        cmp(e.name, "err",   {3'b0, bus_i.stack_err},   {3'b0, e.err});
        cmp(e.name, "pass",  {3'b0, bus_i.cond_pass},   {3'b0, e.pass});
      end
    end
  end

  initial begin : driver
    logic [3:0] cur;
    bus_i.result = '0; bus_i.cout_i = 0; bus_i.vflag_i = 0; bus_i.alucontrol = '0;
    bus_i.flag_we = 0; bus_i.cond = 4'hE; bus_i.push = 0; bus_i.pop = 0;
    clr();

    s_rst = 1; tick("rst", 0, 4'h0, 1, 0, 0, 1);
    tick("reset_state", 1, 4'b0000, 1, 0, 0, 1);
    s_cond = 4'h0; s_we = 1; s_cout = 1;
    tick("zero_bypass", 1, 4'b0000, 1, 0, 0, BYP);
    s_cond = 4'h0; tick("zero_eq", 1, 4'b0110, 1, 0, 0, 1);
    s_we = 1; s_alu = 4'b0010; s_result = 32'h8000_0000; s_v = 1; s_cond = 4'hB;
    tick("logic_bypass", 1, 4'b0110, 1, 0, 0, BYP);
    s_cond = 4'hB; tick("logic_hold_lt", 1, 4'b1010, 1, 0, 0, 1);
    s_we = 1; s_result = 32'h8000_0001; s_v = 1;
    tick("set_1001", 1, 4'b1010, 1, 0, 0, 1);
    s_push = 1; s_cond = 4'h6; tick("push_vs", 1, 4'b1001, 1, 0, 0, 1);
    s_we = 1; s_result = 32'h1; tick("we_after_push", 1, 4'b1001, 0, 0, 0, 1);
    s_pop = 1; s_we = 1; s_cond = 4'h0; tick("pop_with_we", 1, 4'b0000, 0, 0, 0, 0);
    s_cond = 4'hA; tick("pop_restored", 1, 4'b1001, 1, 0, 0, 1);

    s_push = 1; s_we = 1; s_cout = 1; tick("push_we_1", 1, 4'b1001, 1, 0, 0, 1);
    s_push = 1; s_we = 1; s_result = 32'h1; s_v = 1; tick("push_we_2", 1, 4'b0110, 0, 0, 0, 1);
    s_push = 1; tick("push_3", 1, 4'b0001, 0, 0, 0, 1);
    s_push = 1; tick("push_4", 1, 4'b0001, 0, 0, 0, 1);
    s_push = 1; tick("push_5_full", 1, 4'b0001, 0, 1, 0, 1);
    s_pop = 1; tick("pop_1_err", 1, 4'b0001, 0, 1, 1, 1);
    s_pop = 1; tick("pop_2", 1, 4'b0001, 0, 0, 1, 1);
    s_pop = 1; tick("pop_3", 1, 4'b0001, 0, 0, 1, 1);
    s_pop = 1; s_cond = 4'h0; tick("pop_4_lifo", 1, 4'b0110, 0, 0, 1, 1);
    tick("stack_drained", 1, 4'b1001, 1, 0, 1, 1);

    s_rst = 1; s_push = 1; tick("rst_with_push", 1, 4'b1001, 1, 0, 1, 1);
    s_pop = 1; s_we = 1; tick("pop_empty", 1, 4'b0000, 1, 0, 0, 1);
    s_rst = 1; tick("pop_empty_err", 1, 4'b0100, 1, 0, 1, 1);
    s_push = 1; s_pop = 1; s_we = 1; s_result = 32'h8000_0000; s_cout = 1; s_v = 1;
    tick("push_pop_fresh", 1, 4'b0000, 1, 0, 0, 1);
    s_push = 1; tick("push_pop_err", 1, 4'b1011, 1, 0, 1, 1);
    s_push = 1; s_pop = 1; tick("push_pop_count1", 1, 4'b1011, 0, 0, 1, 1);
    s_pop = 1; tick("count_held", 1, 4'b1011, 0, 0, 1, 1);
    tick("popped_once", 1, 4'b1011, 1, 0, 1, 1);

    s_rst = 1; tick("rst_sweep", 0, 4'h0, 1, 0, 0, 1);
    cur = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] f;
      f = 4'(i);
      if (f[3:2] != 2'b11) begin
        s_we = 1; s_cout = f[1]; s_v = f[0];
        s_result = f[2] ? 32'h0 : (f[3] ? 32'h8000_0001 : 32'h1);
        tick("sweep_set", 1, cur, 1, 0, 0, 1);
        cur = f;
        for (int c = 0; c < 16; c++) begin
          s_cond = 4'(c);
          tick($sformatf("sweep_f%h_c%h", f, c), 1, cur, 1, 0, 0, tbl(4'(c), cur));
        end
      end
    end

    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
